// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one combinational multiplier among NUM_REQ requesters.
// Each product is held in a one-entry, requester-tagged result register with a valid/ready handshake.

module mul_simple #(
   parameter int DATA_1_WIDTH = 8,
   parameter int DATA_2_WIDTH = 4,
   parameter int RES_WIDTH    = 16
) (
   input  logic [DATA_1_WIDTH-1:0] a_i,
   input  logic [DATA_2_WIDTH-1:0] b_i,
   output logic [RES_WIDTH-1:0]    res_o
);

   assign res_o = RES_WIDTH'(a_i) * RES_WIDTH'(b_i);

endmodule

module mul_rr_sched #(
   parameter int DATA_1_WIDTH = 8,
   parameter int DATA_2_WIDTH = 4,
   parameter int RES_WIDTH    = 16,
   parameter int NUM_REQ      = 4,
   parameter int ID_WIDTH     = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_1_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_2_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            resp_valid,
   output logic [ID_WIDTH-1:0]             resp_id,
   output logic [RES_WIDTH-1:0]            resp_data,
   input  logic                            resp_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                  state_q;
   logic                    respValid_q;
   logic [ID_WIDTH-1:0]     respId_q;
   logic [RES_WIDTH-1:0]    respData_q;
   logic [ID_WIDTH-1:0]     lastGrant_q;

   logic                    canAccept;
   logic                    grantFound;
   logic [ID_WIDTH-1:0]     grantIdx;
   logic [NUM_REQ-1:0]      grantOneHot;
   logic                    accept;
   logic [DATA_1_WIDTH-1:0] opA;
   logic [DATA_2_WIDTH-1:0] opB;
   logic [RES_WIDTH-1:0]    product;

   assign canAccept = (state_q == EMPTY) || resp_ready;

   // Two descending scans: the wrapped region (index <= lastGrant) is scanned first and
   // then overridden by the region above lastGrant, so the lowest valid index after the
   // pointer wins and the search wraps around to the start otherwise.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i <= int'(lastGrant_q))) begin
            grantFound = 1'b1;
            grantIdx   = ID_WIDTH'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i > int'(lastGrant_q))) begin
            grantFound = 1'b1;
            grantIdx   = ID_WIDTH'(i);
         end
      end
   end

   always_comb begin
      grantOneHot = '0;
      opA         = '0;
      opB         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grantIdx == ID_WIDTH'(i)) begin
            grantOneHot[i] = grantFound && canAccept && !rst;
            opA            = req_a[i*DATA_1_WIDTH +: DATA_1_WIDTH];
            opB            = req_b[i*DATA_2_WIDTH +: DATA_2_WIDTH];
         end
      end
   end

   assign accept = |grantOneHot;

   mul_simple #(
      .DATA_1_WIDTH (DATA_1_WIDTH),
      .DATA_2_WIDTH (DATA_2_WIDTH),
      .RES_WIDTH    (RES_WIDTH)
   ) uMul (
      .a_i   (opA),
      .b_i   (opB),
      .res_o (product)
   );

   // A new accept always overwrites the slot, so a drain and a refill on the same edge keep it FULL.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         respValid_q <= 1'b0;
         respId_q    <= '0;
         respData_q  <= '0;
         lastGrant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= FULL;
                  respValid_q <= 1'b1;
                  respId_q    <= grantIdx;
                  respData_q  <= product;
                  lastGrant_q <= grantIdx;
               end
            end
            FULL: begin
               if (accept) begin
                  respValid_q <= 1'b1;
                  respId_q    <= grantIdx;
                  respData_q  <= product;
                  lastGrant_q <= grantIdx;
               end else if (resp_ready) begin
                  state_q     <= EMPTY;
                  respValid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= EMPTY;
               respValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = grantOneHot;
   assign resp_valid = respValid_q;
   assign resp_id    = respId_q;
   assign resp_data  = respData_q;

endmodule

// File: doc/mul_rr_sched.md
Name: mul_rr_sched

Overview:
- Shares one combinational `mul_simple` multiplier between NUM_REQ requesters.
- Round-robin arbitration; the winner's operands drive the multiplier.
- The product is captured in a one-entry output register with a valid/ready handshake and tagged with the requester ID.
- Sits between client blocks (e.g. filter/accumulator stages) and the shared multiplier.

Parameters:
- DATA_1_WIDTH, 8, width of operand A.
- DATA_2_WIDTH, 4, width of operand B.
- RES_WIDTH, 16, result width; must be >= DATA_1_WIDTH + DATA_2_WIDTH.
- NUM_REQ, 4, number of requesters; range 2..16.
- ID_WIDTH, 2, width of resp_id; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has an operation pending.
- req_a  input  NUM_REQ*DATA_1_WIDTH  operand A per requester; slice i = [i*DATA_1_WIDTH +: DATA_1_WIDTH].
- req_b  input  NUM_REQ*DATA_2_WIDTH  operand B per requester; same slicing.
- req_ready  output  NUM_REQ  one-hot or zero grant; bit i high means requester i is accepted this cycle.
- resp_valid  output  1  result register holds a valid product.
- resp_id  output  ID_WIDTH  index of the requester that produced resp_data.
- resp_data  output  RES_WIDTH  product.
- resp_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - resp_valid=0, resp_id=0, resp_data=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority.
  - FSM goes to EMPTY.
  - Reset mid-operation discards any held result. No req_ready during a cycle where rst=1.
- FSM has two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = (state==EMPTY) | (state==FULL & resp_ready).
- Arbitration (combinational):
  - Search starts at index (last_grant+1) mod NUM_REQ and wraps.
  - The first i with req_valid[i]=1 is the winner g.
  - req_ready[g]=can_accept & |req_valid & ~rst; all other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid=0.
- Accept (req_valid[g] & req_ready[g] at an edge):
  - resp_data <= zero-extended req_a[g] * zero-extended req_b[g], truncated to RES_WIDTH (unsigned).
  - resp_id <= g; last_grant <= g; state <= FULL.
- Latency:
  - Accepted at edge t, so resp_valid=1 after edge t; visible in cycle t+1.
  - Throughput is one op per cycle while resp_ready=1.
- FULL & resp_ready & no new accept: state <= EMPTY, resp_valid <= 0.
- FULL & ~resp_ready:
  - resp_valid, resp_id and resp_data hold stable.
  - All req_ready=0 (backpressure).
- Simultaneous drain and accept: the new result replaces the old one in the same edge; resp_valid stays 1.
- last_grant updates only on accept. Idle cycles do not move the pointer.
- Requester obligations: once req_valid[i]=1, keep it and the operands stable until req_ready[i]=1. The block does not check this.
- Fairness: with all requesters continuously valid and resp_ready=1, grants cycle 0,1,2,...,NUM_REQ-1,0. Any requester waits at most NUM_REQ-1 grants.
- Single multiplier instance: operands are muxed by g; the product width comes from the multiplier's RES_WIDTH.

Test Plan (defaults: DATA_1_WIDTH=8, DATA_2_WIDTH=4, RES_WIDTH=16, NUM_REQ=4):
- Single request: rst 2 cycles; req_valid=4'b0100, a2=8'hFF, b2=4'hF, resp_ready=1 -> req_ready=4'b0100 one cycle; next cycle resp_valid=1, resp_id=2, resp_data=16'h0EF1; following cycle resp_valid=0.
- Round-robin: req_valid=4'b1111 constant, a_i=i+1, b_i=3, resp_ready=1 -> grants 0,1,2,3,0; resp_data 3,6,9,12,3; resp_valid stays 1 every cycle.
- Pointer after reset and skip: after reset, req_valid=4'b1010 -> grant 1 first, then 3, then 1; bits 0 and 2 never granted.
- Backpressure: result held with resp_ready=0 for 5 cycles while req_valid=4'b0001 -> req_ready=0 and resp_data/resp_id stable throughout. Raise resp_ready -> same edge drains and accepts requester 0; resp_valid remains 1 with the new product.
- Reset mid-operation: resp_valid=1 with resp_ready=0, assert rst one cycle -> resp_valid=0, resp_data=0, req_ready=0 during the reset cycle; next grant goes to requester 0 when all are valid.
- Random stress: 2000 cycles of random req_valid/operands (operands held stable until accepted) and random resp_ready -> every accepted op appears exactly once, in order, with resp_data == a*b and the correct resp_id. No requester starves beyond 3 intervening grants.
